// File: rtl/step_ctrl.sv
// Step-pulse generator: debounced single-step button or free-running divider drives STEP.
// Latency: key fall to STEP is 2 (sync) + DEBOUNCE_CYCLES cycles; run mode steps every RUN_DIV cycles.
// Backpressure: none; STEP is a fire-and-forget one-cycle pulse.
//
// Ports:
//   CLK       board clock
//   RST       asynchronous active-low reset
//   KEY_STEP  raw active-low step button (asynchronous)
//   KEY_RUN   raw active-low run/stop button (asynchronous), each press toggles RUN_MODE
//   STEP      registered one-cycle step pulse
//   RUN_MODE  1 = free-run, 0 = single-step
//   STEP_CNT  number of STEP pulses since reset, wraps at 2^CNT_W
//
// Optional feature macro: STEP_CTRL_CNT_EN. When undefined, the step counter is not
// built and STEP_CNT is tied to zero.

module step_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int RUN_DIV         = 12500000,
    parameter int CNT_W           = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             KEY_STEP,
    input  logic             KEY_RUN,
    output logic             STEP,
    output logic             RUN_MODE,
    output logic [CNT_W-1:0] STEP_CNT
);

    // The debounce counter only ever needs to reach DEBOUNCE_CYCLES-2: the transition
    // out of a WAIT state happens on the edge where it would become DEBOUNCE_CYCLES-1,
    // so exactly DEBOUNCE_CYCLES consecutive stable samples are seen (including the
    // sample that left IDLE/HELD).
    localparam int DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 2);

    localparam int DIV_W = (RUN_DIV > 2) ? $clog2(RUN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } db_state_t;

    // Bit 0 = step key, bit 1 = run key.
    logic [1:0] key_raw;
    logic [1:0] sync1;
    logic [1:0] sync2;
    logic [1:0] press;

    assign key_raw = {KEY_RUN, KEY_STEP};

    // Two-flop synchronizers, reset to the released level.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync1 <= 2'b11;
            sync2 <= 2'b11;
        end else begin
            sync1 <= key_raw;
            sync2 <= sync1;
        end
    end

    // One debounce FSM per key. press_q is high for the single cycle after the
    // press has been accepted; a held key never re-fires until a debounced release.
    for (genvar k = 0; k < 2; k++) begin : g_db
        db_state_t       state;
        logic [DB_W-1:0] cnt;
        logic            press_q;
        logic            key_s;

        assign key_s = sync2[k];

        always_ff @(posedge CLK or negedge RST) begin
            if (!RST) begin
                state   <= IDLE;
                cnt     <= '0;
                press_q <= 1'b0;
            end else begin
                press_q <= 1'b0;
                case (state)
                    IDLE: begin
                        if (!key_s) begin
                            state <= PRESS_WAIT;
                            cnt   <= '0;
                        end
                    end
                    PRESS_WAIT: begin
                        if (key_s) begin
                            state <= IDLE;
                        end else if (cnt == DB_LAST) begin
                            state   <= HELD;
                            press_q <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    HELD: begin
                        if (key_s) begin
                            state <= RELEASE_WAIT;
                            cnt   <= '0;
                        end
                    end
                    RELEASE_WAIT: begin
                        if (!key_s) begin
                            state <= HELD;
                        end else if (cnt == DB_LAST) begin
                            state <= IDLE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end

        assign press[k] = press_q;
    end

    logic             press_step;
    logic             press_run;
    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] div_nxt;
    logic             step_nxt;

    assign press_step = press[0];
    assign press_run  = press[1];

    // Every decision uses RUN_MODE before a toggle lands. A toggle in either
    // direction suppresses both step sources for that edge and clears the divider,
    // so STEP is registered in the same cycle the divider shows RUN_DIV-1.
    always_comb begin
        div_nxt  = '0;
        step_nxt = 1'b0;
        if (RUN_MODE && !press_run) begin
            div_nxt = (div == DIV_LAST) ? '0 : div + 1'b1;
        end
        if (!press_run) begin
            if (RUN_MODE) begin
                step_nxt = (div_nxt == DIV_LAST);
            end else begin
                step_nxt = press_step;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            RUN_MODE <= 1'b0;
            div      <= '0;
            STEP     <= 1'b0;
        end else begin
            if (press_run) begin
                RUN_MODE <= ~RUN_MODE;
            end
            div  <= div_nxt;
            STEP <= step_nxt;
        end
    end

`ifdef STEP_CTRL_CNT_EN
    logic [CNT_W-1:0] step_cnt_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            step_cnt_q <= '0;
        end else if (STEP) begin
            step_cnt_q <= step_cnt_q + 1'b1;
        end
    end

    assign STEP_CNT = step_cnt_q;
`else
    assign STEP_CNT = '0;
`endif

endmodule

// File: tb/tb_step_ctrl.sv
// Bench for step_ctrl with DEBOUNCE_CYCLES=4, RUN_DIV=5, CNT_W=4.
// Cycle N means the value just after the Nth rising edge following reset release;
// inputs are driven on falling edges and outputs sampled on falling edges.

module tb_step_ctrl;

    logic       clk;
    logic       rst;
    logic       key_step;
    logic       key_run;
    logic       step;
    logic       run_mode;
    logic [3:0] step_cnt;

    step_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .RUN_DIV        (5),
        .CNT_W          (4)
    ) dut (
        .CLK     (clk),
        .RST     (rst),
        .KEY_STEP(key_step),
        .KEY_RUN (key_run),
        .STEP    (step),
        .RUN_MODE(run_mode),
        .STEP_CNT(step_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         len;   // cycles the inputs are held, outputs checked every cycle
        logic       ks;
        logic       kr;
        logic       step;
        logic       mode;
        logic [3:0] cnt;
    } vec_t;

    vec_t tbl[$];
    int   cyc;
    int   n_vec;
    int   n_err;

    function automatic void add(input int len, input logic ks, input logic kr,
                                input logic s, input logic m, input logic [3:0] c);
        vec_t v;
        v.len  = len;
        v.ks   = ks;
        v.kr   = kr;
        v.step = s;
        v.mode = m;
        v.cnt  = c;
        tbl.push_back(v);
    endfunction

    function automatic logic [3:0] exp_cnt(input logic [3:0] c);
`ifdef STEP_CTRL_CNT_EN
        return c;
`else
        return 4'd0;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic s, input logic m, input logic [3:0] c);
        logic [3:0] ce;
        ce = exp_cnt(c);
        n_vec++;
        if (step !== s || run_mode !== m || step_cnt !== ce) begin
            n_err++;
            $display("FAIL %s cyc=%0d: STEP=%b RUN_MODE=%b STEP_CNT=%0d, expected %b %b %0d",
                     name, cyc, step, run_mode, step_cnt, s, m, ce);
        end
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        cyc      = -1;
        key_step = 1'b1;
        key_run  = 1'b1;
        rst      = 1'b1;
        #3 rst = 1'b0;
        repeat (3) @(negedge clk);
        check("reset", 1'b0, 1'b0, 4'd0);
        rst = 1'b1;
        cyc = -1;

        // Clean press at 10 held 20 cycles: STEP only at 16.
        add(10, 1, 1, 0, 0, 0);
        add( 6, 0, 1, 0, 0, 0);
        add( 1, 0, 1, 1, 0, 0);
        add(13, 0, 1, 0, 0, 1);
        add(20, 1, 1, 0, 0, 1);
        // Bounce 50..57, then held low from 58: single STEP at 64.
        for (int i = 0; i < 8; i++) add(1, logic'(i % 2), 1, 0, 0, 1);
        add( 6, 0, 1, 0, 0, 1);
        add( 1, 0, 1, 1, 0, 1);
        add(10, 0, 1, 0, 0, 2);
        add(10, 1, 1, 0, 0, 2);
        // Run key down at 85, event at 90, RUN_MODE at 91, steps at 95/100/105/110.
        // Step key pressed during run (event at 101) must be ignored.
        add( 6, 1, 0, 0, 0, 2);
        add( 4, 1, 0, 0, 1, 2);
        add( 1, 1, 0, 1, 1, 2);
        add( 4, 0, 1, 0, 1, 3);
        add( 1, 0, 1, 1, 1, 3);
        add( 4, 0, 1, 0, 1, 4);
        add( 1, 0, 1, 1, 1, 4);
        add( 3, 1, 1, 0, 1, 5);
        // Run key down at 109: toggle event at 114, colliding with terminal count at 115.
        add( 1, 1, 0, 0, 1, 5);
        add( 1, 1, 0, 1, 1, 5);
        add( 4, 1, 0, 0, 1, 6);
        add( 5, 1, 0, 0, 0, 6);
        add(15, 1, 1, 0, 0, 6);

        foreach (tbl[v]) begin
            key_step = tbl[v].ks;
            key_run  = tbl[v].kr;
            for (int j = 0; j < tbl[v].len; j++) begin
                tick();
                check($sformatf("vec%0d", v), tbl[v].step, tbl[v].mode, tbl[v].cnt);
            end
        end

        // Enter run mode, then stop mid-debounce (step FSM in PRESS_WAIT, count 2).
        key_run = 1'b0;
        repeat (6) tick();
        key_run = 1'b1;
        tick();
        check("run_on", 1'b0, 1'b1, 4'd6);
        key_step = 1'b0;
        repeat (5) tick();
        check("pre_rst", 1'b0, 1'b1, 4'd7);
        rst = 1'b0;
        #1;
        check("async_rst", 1'b0, 1'b0, 4'd0);
        key_step = 1'b1;
        for (int j = 0; j < 2; j++) begin
            tick();
            check("in_rst", 1'b0, 1'b0, 4'd0);
        end
        rst = 1'b1;
        key_step = 1'b0;
        for (int j = 0; j < 3; j++) begin
            tick();
            check("glitch", 1'b0, 1'b0, 4'd0);
        end
        key_step = 1'b1;
        for (int j = 0; j < 12; j++) begin
            tick();
            check("glitch_after", 1'b0, 1'b0, 4'd0);
        end

        // 17 single-step presses: counter wraps to 1.
        for (int i = 1; i <= 17; i++) begin
            key_step = 1'b0;
            for (int off = 0; off < 16; off++) begin
                if (off == 8) key_step = 1'b1;
                tick();
                check($sformatf("wrap%0d_%0d", i, off), logic'(off == 6), 1'b0,
                      (off >= 7) ? 4'(i) : 4'(i - 1));
            end
        end

        // Both keys fall together: toggle to run applies, step event discarded.
        key_step = 1'b0;
        key_run  = 1'b0;
        for (int off = 0; off < 10; off++) begin
            tick();
            check($sformatf("both_%0d", off), 1'b0, logic'(off >= 6), 4'd1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
